// File: rtl/acc_burst_extract_if.sv
// Burst-extract handshake bundle: beat input, accumulator tap, result queue.
// Optional res_beats field exists only under ACC_BURST_COUNT_EN.
interface acc_burst_extract_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             beat_valid;
    logic             beat_last;
    logic [WIDTH-1:0] acc_value;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
`ifdef ACC_BURST_COUNT_EN
    logic [CNT_W-1:0] res_beats;
`endif
    logic             busy;
    logic             drop_err;

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("acc_burst_extract_if: bad parameters");
    end

    modport master (
        output beat_valid, beat_last, acc_value, res_ready,
`ifdef ACC_BURST_COUNT_EN
        input  res_beats,
`endif
        input  res_valid, res_sum, busy, drop_err
    );

    modport slave (
        input  beat_valid, beat_last, acc_value, res_ready,
`ifdef ACC_BURST_COUNT_EN
        output res_beats,
`endif
        output res_valid, res_sum, busy, drop_err
    );
endinterface

// File: rtl/acc_burst_extract.sv
// Per-burst sum extraction from a free-running delayed accumulator.
// Define ACC_BURST_COUNT_EN to add a saturating beat count per result.
module acc_burst_extract #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 10,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                reset,
    acc_burst_extract_if.slave bus
);

`ifdef ACC_BURST_COUNT_EN
    localparam int EW = WIDTH + CNT_W;
`else
    localparam int EW = WIDTH;
`endif

    if (LATENCY < 2 || LATENCY > 64 || CNT_W < 1) begin : g_bad_cfg
        $error("acc_burst_extract: bad parameters");
    end

    typedef enum logic {IDLE, OPEN} state_t;

    state_t           state_q, state_d;
    logic             first_tag;
    logic             last_tag;
    logic [LATENCY:1] first_sr_q;
    logic [LATENCY:1] last_sr_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] new_sum;
    logic [EW-1:0]    new_entry;
    logic [EW-1:0]    head_q;
    logic [EW-1:0]    tail_q;
    logic [1:0]       fill_q;
    logic             drop_q;
    logic             push;
    logic             pop;

    // Burst-open state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Tag beats as FIRST/LAST and track whether a burst is open
    always_comb begin
        state_d   = state_q;
        first_tag = 1'b0;
        last_tag  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.beat_valid) begin
                    first_tag = 1'b1;
                    last_tag  = bus.beat_last;
                    if (!bus.beat_last) state_d = OPEN;
                end
            end
            OPEN: begin
                if (bus.beat_valid && bus.beat_last) begin
                    last_tag = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tags ride alongside the accumulator pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            first_sr_q <= '0;
            last_sr_q  <= '0;
        end else begin
            first_sr_q <= {first_sr_q[LATENCY-1:1], first_tag};
            last_sr_q  <= {last_sr_q[LATENCY-1:1], last_tag};
        end
    end

    // Snapshot the accumulator one cycle before the first beat lands
    always_ff @(posedge clk) begin
        if (reset)                         base_q <= '0;
        else if (first_sr_q[LATENCY-1])    base_q <= bus.acc_value;
    end

    assign new_sum = bus.acc_value - base_q;
    assign push    = last_sr_q[LATENCY];
    assign pop     = (fill_q != 2'd0) && bus.res_ready;

`ifdef ACC_BURST_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_sr_q [1:LATENCY];

    // Running count including the current beat, saturating
    always_comb begin
        beat_cnt = cnt_q;
        if (first_tag)   beat_cnt = CNT_W'(1);
        else if (!(&cnt_q)) beat_cnt = cnt_q + 1'b1;
    end

    // Count register and its delay line toward the result tap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            for (int i = 1; i <= LATENCY; i++) cnt_sr_q[i] <= '0;
        end else begin
            if (bus.beat_valid) cnt_q <= beat_cnt;
            cnt_sr_q[1] <= beat_cnt;
            for (int i = 2; i <= LATENCY; i++) cnt_sr_q[i] <= cnt_sr_q[i-1];
        end
    end

    assign new_entry     = {cnt_sr_q[LATENCY], new_sum};
    assign bus.res_beats = head_q[EW-1:WIDTH];
`else
    assign new_entry = new_sum;
`endif

    // Two-entry result queue; a push into a full, stalled queue is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= 2'd0;
            drop_q <= 1'b0;
        end else begin
            unique case (fill_q)
                2'd0: begin
                    if (push) begin
                        head_q <= new_entry;
                        fill_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= new_entry;
                    end else if (pop) begin
                        fill_q <= 2'd0;
                    end else if (push) begin
                        tail_q <= new_entry;
                        fill_q <= 2'd2;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) tail_q <= new_entry;
                        else      fill_q <= 2'd1;
                    end else if (push) begin
                        drop_q <= 1'b1;
                    end
                end
                default: fill_q <= 2'd0;
            endcase
        end
    end

    assign bus.res_valid = (fill_q != 2'd0);
    assign bus.res_sum   = head_q[WIDTH-1:0];
    assign bus.drop_err  = drop_q;
    assign bus.busy      = (state_q == OPEN) || (|first_sr_q) || (|last_sr_q);

endmodule

// File: tb/tb_acc_burst_extract.sv
// Randomized and directed bench for acc_burst_extract.
// Models the delayed accumulator and per-burst result queue behaviourally.
module tb_acc_burst_extract;
    localparam int W  = 32;
    localparam int L  = 10;
    localparam int CW = 16;

    typedef struct {
        int          due;
        logic [31:0] sum;
        int          beats;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    acc_burst_extract_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    acc_burst_extract #(.WIDTH(W), .LATENCY(L), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] total;
    logic [31:0] pipe[$];
    res_t        pend[$];
    res_t        mq[$];
    bit          open_b = 1'b0;
    logic [31:0] cur_sum;
    int          cur_cnt;
    int          last_beat = -1000;
    bit          drop_exp = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic acc_set(input logic [31:0] v);
        total = v;
        pipe.delete();
        repeat (L) pipe.push_back(v);
        bus.acc_value = v;
    endtask

    task automatic check_outputs();
        check("res_valid", 64'(bus.res_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("res_sum", 64'(bus.res_sum), 64'(mq[0].sum));
`ifdef ACC_BURST_COUNT_EN
            check("res_beats", 64'(bus.res_beats), 64'(mq[0].beats));
`endif
        end
        check("drop_err", 64'(bus.drop_err), 64'(drop_exp));
        check("busy", 64'(bus.busy),
              64'(open_b || (last_beat >= cyc - L)));
    endtask

    task automatic step(input bit bv, input bit bl, input logic [31:0] c);
        bus.beat_valid = bv;
        bus.beat_last  = bl;
        if (bv) total = total + c;
        pipe.push_back(total);
        bus.acc_value = pipe.pop_front();
        if (bv) begin
            if (!open_b) begin
                cur_sum = '0;
                cur_cnt = 0;
            end
            cur_sum = cur_sum + c;
            if (cur_cnt < (1 << CW) - 1) cur_cnt++;
            last_beat = cyc;
            if (bl) begin
                pend.push_back('{cyc + L, cur_sum, cur_cnt});
                open_b = 1'b0;
            end else begin
                open_b = 1'b1;
            end
        end
        @(posedge clk);
        if (mq.size() > 0 && bus.res_ready) void'(mq.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (mq.size() < 2) mq.push_back(pend[0]);
            else               drop_exp = 1'b1;
            void'(pend.pop_front());
        end
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        cyc += n;
        @(negedge clk);
        reset = 1'b0;
        pend.delete();
        mq.delete();
        open_b    = 1'b0;
        drop_exp  = 1'b0;
        last_beat = -1000;
        acc_set(32'h0);
        check("rst_valid", 64'(bus.res_valid), 64'h0);
        check("rst_sum", 64'(bus.res_sum), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_drop", 64'(bus.drop_err), 64'h0);
`ifdef ACC_BURST_COUNT_EN
        check("rst_beats", 64'(bus.res_beats), 64'h0);
`endif
    endtask

    initial begin
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
        bus.res_ready  = 1'b1;
        acc_set(32'h0);
        do_reset(3);
        idle(L);

        // 4-beat burst on a preloaded accumulator
        acc_set(32'h0000_0100);
        repeat (3) step(1'b1, 1'b0, 32'd3);
        step(1'b1, 1'b1, 32'd3);
        idle(L + 4);

        // Wrap through 2^32
        acc_set(32'hFFFF_FFF0);
        step(1'b1, 1'b0, 32'h10);
        step(1'b1, 1'b1, 32'h10);
        idle(L + 4);

        // Back-to-back single-beat bursts
        step(1'b1, 1'b1, 32'd5);
        step(1'b1, 1'b1, 32'd7);
        step(1'b1, 1'b1, 32'd9);
        idle(L + 4);

        // Stalled consumer: third result is dropped
        bus.res_ready = 1'b0;
        step(1'b1, 1'b1, 32'd1);
        step(1'b1, 1'b1, 32'd2);
        step(1'b1, 1'b1, 32'd3);
        idle(L + 4);
        bus.res_ready = 1'b1;
        idle(4);

        // Idle gap inside a burst
        do_reset(2);
        idle(L);
        step(1'b1, 1'b0, 32'd4);
        idle(2);
        step(1'b1, 1'b0, 32'd5);
        step(1'b1, 1'b1, 32'd6);
        idle(L + 4);

        // Reset in the middle of a burst
        step(1'b1, 1'b0, 32'd11);
        step(1'b1, 1'b0, 32'd12);
        do_reset(2);
        idle(L);
        step(1'b1, 1'b1, 32'd6);
        idle(L + 4);

        // Random traffic with random back-pressure
        for (int i = 0; i < 500; i++) begin
            bit          bv;
            bit          bl;
            logic [31:0] c;
            bus.res_ready = ($urandom_range(0, 3) != 0);
            bv = ($urandom_range(0, 1) == 1);
            bl = ($urandom_range(0, 2) == 0);
            c  = bv ? $urandom : 32'h0;
            step(bv, bl, c);
        end
        bus.res_ready = 1'b1;
        step(1'b1, 1'b1, $urandom);
        idle(L + 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/acc_burst_extract.md
Name: acc_burst_extract

Overview:
- Downstream consumer of the free-running CSA accumulator (`acc_value` = accumulator's `final_acc`).
- The accumulator never clears between transactions. This block isolates the sum contributed by each operand burst:
  - snapshots `acc_value` just before the burst's first beat lands;
  - snapshots it again after the last beat lands;
  - emits the difference.
- Results go out through a 2-entry ready/valid output queue toward the register/readout side.

Parameters:
- `WIDTH`, 32: accumulator and result width.
- `LATENCY`, 10: cycles from operands presented at the accumulator's A/B inputs until their contribution is visible on `acc_value`. Legal range 2..64.
- `CNT_W`, 16: beat counter width. Used only when `ACC_BURST_COUNT_EN` is defined.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `beat_valid` in 1: high in the same cycle the operand pair is presented to the accumulator.
- `beat_last` in 1: qualifies `beat_valid`; marks the final beat of a burst.
- `acc_value` in WIDTH: accumulator output.
- `res_valid` out 1: head of output queue is valid.
- `res_ready` in 1: consumer accepts head when `res_valid` and `res_ready` are both high.
- `res_sum` out WIDTH: burst sum, modulo 2^WIDTH.
- `res_beats` out CNT_W: beats in the burst. Present only with `ACC_BURST_COUNT_EN`.
- `busy` out 1: a burst is open or a tag is still in flight in the delay line.
- `drop_err` out 1: sticky; a result was discarded because the queue was full.

Behaviour:

Input tracking FSM (IDLE, OPEN):
- IDLE + `beat_valid`: the beat is tagged FIRST.
  - If `beat_last` is also high: tag FIRST|LAST, stay IDLE.
  - Otherwise: go to OPEN.
- OPEN + `beat_valid` + `beat_last`: tag LAST, go to IDLE.
- `beat_last` without `beat_valid`: ignored.
- Idle cycles inside a burst (`beat_valid` low): allowed. Upstream drives zero operands on those cycles, which is not checked here.

Tag delay line:
- Shift register of LATENCY stages, carrying FIRST and LAST bits per stage.
- Beat tagged at cycle t:
  - FIRST reaches tap LATENCY-1 at cycle t+LATENCY-1;
  - LAST reaches tap LATENCY at cycle t+LATENCY.

Capture and result formation:
- FIRST at its tap: `base_q` <= `acc_value`. This value excludes the first beat.
- LAST at its tap: result = `acc_value` − `base_q`, computed mod 2^WIDTH with no overflow flag. The result is pushed to the queue on that edge.
- Same-cycle FIRST and LAST taps (back-to-back bursts): the result uses the old `base_q`, and `base_q` then loads the new value on the same edge.
- Single-beat burst: base captured at t+L-1, result at t+L.

Latency:
- `res_valid` rises at cycle t_last+LATENCY+1 when the queue was empty.

Output queue:
- 2 entries, registered outputs.
- Push and pop in the same cycle are allowed in every state.
- Full with `res_ready` high: pop and push both happen; no drop.
- Full with `res_ready` low on a push: the new result is dropped, the queue is unchanged, and `drop_err` <= 1. `drop_err` is cleared only by reset.
- `res_sum` holds the head value while `res_valid` && !`res_ready`.

Reset (synchronous, any cycle including mid-burst):
- FSM <= IDLE; delay line <= 0; `base_q` <= 0; queue emptied.
- Outputs: `res_valid` 0, `res_sum` 0, `res_beats` 0, `busy` 0, `drop_err` 0.
- An interrupted burst produces no result. The first burst after reset starts fresh.
- The accumulator shares this reset; its pipeline contents are not trusted. Upstream holds `beat_valid` low for LATENCY cycles after reset.

Optional Feature:
- Macro: `ACC_BURST_COUNT_EN`.
- Defined:
  - a CNT_W beat counter loads 1 on a FIRST beat and increments on each later valid beat, saturating at all-ones;
  - the count travels with the LAST tag through the delay line;
  - it is stored in the queue alongside the sum and driven on `res_beats`.
- Undefined:
  - no counter and no `res_beats` port;
  - delay line carries 2 bits per stage; queue entry is WIDTH bits.

Test Plan:
- Accumulator pre-loaded to 0x00000100, then a 4-beat burst with A=1, B=2 per beat → one result, `res_sum`=0x0000000C, `res_beats`=4, at t_last+LATENCY+1.
- Wrap: base `acc_value` 0xFFFFFFF0, burst adds 0x20 → `res_sum`=0x00000020, `drop_err` stays 0.
- Three back-to-back single-beat bursts (`beat_valid`=`beat_last`=1 for 3 cycles) with A+B = 5, 7, 9 → results 5, 7, 9 in order, each `res_beats`=1.
- `res_ready` held low, 3 single-beat bursts → first 2 results kept, third dropped, `drop_err`=1. Then raise `res_ready` → two pops, values correct.
- Burst of 3 beats with 2 idle cycles between beats 1 and 2 (zero operands) → `res_sum` = sum of the 3 beats, `res_beats`=3.
- Reset asserted mid-burst after 2 beats, followed by a clean 1-beat burst of 6 → no result from the aborted burst, `busy`=0 after reset, single result `res_sum`=6.
